div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multicycle 32-bit integer divider for the MIPS datapath, the inverse companion of the Booth multiplier.
- Executes DIV (signed) and DIVU (unsigned) with a restoring shift-subtract algorithm, one quotient bit per clock.
- Delivers remainder on div_hi and quotient on div_lo for the HI/LO registers.
- Uses a start/done handshake driven by the control FSM, which stalls until done.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported.

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
op_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
A  input  32  dividend; sampled with start
B  input  32  divisor; sampled with start
div_hi  output  32  remainder
div_lo  output  32  quotient
done  output  1  one-cycle pulse: results valid
busy  output  1  high in every state except IDLE
div_zero  output  1  divisor was zero for the last completed operation

Behaviour:
- Reset (reset=1 at an edge):
  - state=IDLE; div_hi=0, div_lo=0, done=0, div_zero=0, internal counter/registers=0.
  - Reset has priority over start on the same edge and aborts any operation in flight.
  - No result or done is produced for an aborted operation.
- States: IDLE, ITER, FIXUP, DONE.
- IDLE:
  - On an edge with start=1, capture A, B, op_signed.
  - If op_signed=1: dividend magnitude = |A|, divisor magnitude = |B|; record sign_q = A[31]^B[31] and sign_r = A[31]. If op_signed=0, use raw values with both signs 0.
  - Load 64-bit remainder:quotient register = {32'b0, dividend magnitude} and set count=0.
  - If B==0, go to FIXUP; otherwise go to ITER.
- ITER, one step per edge:
  - Shift the {rem,quo} register left by 1.
  - trial = rem − divisor magnitude, computed in 33 bits.
  - If trial is non-negative: rem = trial[31:0] and quo[0]=1; else quo[0]=0.
  - count increments each step. After the 32nd step (count==31 at the edge) go to FIXUP.
- FIXUP, single edge:
  - If B==0: div_lo=32'hFFFFFFFF, div_hi=A (unmodified), div_zero=1.
  - Otherwise: div_lo = sign_q ? −quo : quo; div_hi = sign_r ? −rem : rem; div_zero=0.
  - Set done=1 and go to DONE.
- DONE, single edge: done=0, go to IDLE.
- Latency, with the start-capture edge = edge 0:
  - Normal operation: done is high for exactly the cycle after edge 33; results update at edge 33.
  - Divide by zero: done is high after edge 1.
  - A new start is accepted at edge 35 at the earliest (normal) or edge 3 (divide by zero).
- Result holding: div_hi, div_lo and div_zero hold their last values until the next FIXUP or reset. They are not cleared after done.
- start while busy=1 is ignored and is not queued. A, B and op_signed may change freely after the capture edge without affecting the operation.
- Sign rules: the quotient truncates toward zero; the remainder takes the sign of the dividend.
- Overflow: 0x80000000 / 0xFFFFFFFF (signed) yields div_lo=0x80000000 and div_hi=0 with no flag. This falls out of the 32-bit magnitude arithmetic and needs no special-casing.
- Unsigned full range: operands up to 0xFFFFFFFF handled exactly.
- done and busy are registered outputs; there is no combinational path from inputs to outputs.

Test Plan:
- Signed positive: DIV A=7, B=2 -> done after edge 33, div_lo=3, div_hi=1, div_zero=0, busy high edges 0–34.
- Signed mixed sign: DIV A=−7 (0xFFFFFFF9), B=2 -> div_lo=0xFFFFFFFD, div_hi=0xFFFFFFFF; then DIV A=7, B=−2 -> div_lo=0xFFFFFFFD, div_hi=1.
- Unsigned range: DIVU A=0xFFFFFFFF, B=16 -> div_lo=0x0FFFFFFF, div_hi=0xF; repeat as DIV -> div_lo=0, div_hi=0xFFFFFFFF.
- Divide by zero: DIV A=0x1234, B=0 -> done after edge 1, div_lo=0xFFFFFFFF, div_hi=0x1234, div_zero=1; next valid divide clears div_zero.
- Overflow corner: DIV A=0x80000000, B=0xFFFFFFFF -> div_lo=0x80000000, div_hi=0.
- Reset and busy handling:
  - Start 100/7, then assert reset at edge 10 -> all outputs 0, no done pulse, IDLE next cycle.
  - Start 100/7, then assert start with A=9, B=3 at edge 5 -> ignored; first result 14 r 2.
  - A following start after done gives 3 r 0.

Source files
------------

// File: rtl/div_unit_if.sv
// div_unit_if: handshake and operand/result bundle between the control FSM
// and the multicycle divider.
//   master (control FSM): drives start, op_signed, A, B; observes results.
//   slave  (div_unit)   : samples request fields; drives div_hi, div_lo,
//                         done, busy, div_zero.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic             done;
  logic             busy;
  logic             div_zero;

  modport master (
    output start, op_signed, A, B,
    input  div_hi, div_lo, done, busy, div_zero
  );

  modport slave (
    input  start, op_signed, A, B,
    output div_hi, div_lo, done, busy, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multicycle 32-bit restoring divider for DIV / DIVU.
// One quotient bit per clock; remainder on div_hi, quotient on div_lo.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous, active-high; aborts any operation in flight
//   bus   - div_unit_if.slave (start, op_signed, A, B in;
//           div_hi, div_lo, done, busy, div_zero out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands captured on the start edge
// ITER  | one shift-subtract step per edge, 32 steps
// FIXUP | apply result signs (or divide-by-zero result), pulse done
// DONE  | done drops, return to IDLE
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clock,
  input logic       reset,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [4:0]         count_q;
  logic [2*WIDTH-1:0] rq_q;       // {remainder, quotient}
  logic [WIDTH-1:0]   dvsr_q;
  logic [WIDTH-1:0]   a_q;        // raw dividend, returned as remainder on /0
  logic               sign_q_q;
  logic               sign_r_q;
  logic               b_zero_q;

  logic [WIDTH-1:0]   div_hi_q;
  logic [WIDTH-1:0]   div_lo_q;
  logic               done_q;
  logic               busy_q;
  logic               div_zero_q;

  logic [WIDTH-1:0]   dvnd_mag;
  logic [WIDTH-1:0]   dvsr_mag;
  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;

  // Magnitudes of the request operands. |0x80000000| is 0x80000000 as an
  // unsigned value, which is what makes the overflow case come out right.
  always_comb begin
    dvnd_mag = bus.A;
    dvsr_mag = bus.B;
    if (bus.op_signed) begin
      if (bus.A[WIDTH-1]) dvnd_mag = '0 - bus.A;
      if (bus.B[WIDTH-1]) dvsr_mag = '0 - bus.B;
    end
  end

  // One restoring step. The shifted-out remainder bit is kept so the
  // partial remainder is 33 bits; unsigned divisors above 2^31 need it.
  always_comb begin
    partial = rq_q[2*WIDTH-1:WIDTH-1];
    trial   = partial - {1'b0, dvsr_q};
    rem_d   = rq_q[2*WIDTH-2:WIDTH-1];
    quo_d   = {rq_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_d    = trial[WIDTH-1:0];
      quo_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rq_q       <= '0;
      dvsr_q     <= '0;
      a_q        <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      b_zero_q   <= 1'b0;
      div_hi_q   <= '0;
      div_lo_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q      <= bus.A;
            dvsr_q   <= dvsr_mag;
            rq_q     <= {{WIDTH{1'b0}}, dvnd_mag};
            count_q  <= '0;
            sign_q_q <= bus.op_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            sign_r_q <= bus.op_signed & bus.A[WIDTH-1];
            b_zero_q <= (bus.B == '0);
            busy_q   <= 1'b1;
            state_q  <= (bus.B == '0) ? S_FIXUP : S_ITER;
          end
        end
        S_ITER: begin
          rq_q    <= {rem_d, quo_d};
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          if (b_zero_q) begin
            div_lo_q   <= '1;
            div_hi_q   <= a_q;
            div_zero_q <= 1'b1;
          end else begin
            div_lo_q   <= sign_q_q ? ('0 - rq_q[WIDTH-1:0]) : rq_q[WIDTH-1:0];
            div_hi_q   <= sign_r_q ? ('0 - rq_q[2*WIDTH-1:WIDTH])
                                   : rq_q[2*WIDTH-1:WIDTH];
            div_zero_q <= 1'b0;
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.div_hi   = div_hi_q;
  assign bus.div_lo   = div_lo_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors with hand-computed results for div_unit.
module tb_div_unit;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   edge_cnt;
  int   e0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial edge_cnt = 0;
  always @(posedge clock) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request and step past the capture edge (edge 0).
  task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.start     = 1'b1;
    bus.op_signed = sg;
    bus.A         = a;
    bus.B         = b;
    @(posedge clock);
    #1;
    e0            = edge_cnt;
    bus.start     = 1'b0;
    bus.op_signed = ~sg;
    bus.A         = $urandom;
    bus.B         = $urandom;
  endtask

  task automatic finish_div(input string tag, input logic [31:0] exp_lo,
                            input logic [31:0] exp_hi, input logic exp_z,
                            input int exp_lat);
    int lat;
    check({tag, " busy"}, {31'b0, bus.busy}, 32'd1);
    while (!bus.done && (edge_cnt - e0) < 100) begin
      @(posedge clock);
      #1;
    end
    lat = edge_cnt - e0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " lo"}, bus.div_lo, exp_lo);
    check({tag, " hi"}, bus.div_hi, exp_hi);
    check({tag, " zero"}, {31'b0, bus.div_zero}, {31'b0, exp_z});
    @(posedge clock);
    #1;
    check({tag, " done pulse"}, {31'b0, bus.done}, 32'd0);
    check({tag, " busy after"}, {31'b0, bus.busy}, 32'd0);
    check({tag, " lo held"}, bus.div_lo, exp_lo);
  endtask

  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input logic exp_z,
                         input int exp_lat);
    launch(sg, a, b);
    finish_div(tag, exp_lo, exp_hi, exp_z, exp_lat);
  endtask

  initial begin
    int seen;
    n_checks      = 0;
    n_fail        = 0;
    e0            = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op_signed = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst lo", bus.div_lo, 32'h0);
    check("rst hi", bus.div_hi, 32'h0);
    check("rst done", {31'b0, bus.done}, 32'd0);
    check("rst busy", {31'b0, bus.busy}, 32'd0);
    check("rst zero", {31'b0, bus.div_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_div("7/2",       1'b1, 32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 33);
    run_div("-7/2",      1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    run_div("7/-2",      1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 33);
    run_div("divu max",  1'b0, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 32'hF,        1'b0, 33);
    run_div("div -1/16", 1'b1, 32'hFFFFFFFF, 32'd16,       32'h0,        32'hFFFFFFFF, 1'b0, 33);
    run_div("divu big",  1'b0, 32'hFFFFFFFF, 32'h80000001, 32'd1,        32'h7FFFFFFE, 1'b0, 33);
    run_div("div0",      1'b1, 32'h1234,     32'h0,        32'hFFFFFFFF, 32'h1234,     1'b1, 1);
    run_div("after div0",1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33);
    run_div("ovf",       1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 33);

    // Abort with reset at edge 10: outputs clear, no done afterwards.
    launch(1'b1, 32'd100, 32'd7);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort lo", bus.div_lo, 32'h0);
    check("abort hi", bus.div_hi, 32'h0);
    check("abort busy", {31'b0, bus.busy}, 32'd0);
    check("abort done", {31'b0, bus.done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    check("abort quiet", seen, 0);

    // start while busy is ignored, then the next request runs normally.
    launch(1'b1, 32'd100, 32'd7);
    repeat (4) @(posedge clock);
    @(negedge clock);
    bus.start     = 1'b1;
    bus.op_signed = 1'b1;
    bus.A         = 32'd9;
    bus.B         = 32'd3;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    finish_div("ignored start", 32'd14, 32'd2, 1'b0, 33);
    run_div("9/3", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
